dmem_lsu_adapter: RTL and testbench

//  Single-clock load/store front end for the byte-write true dual port block RAM (port A, HIGH_PERFORMANCE, 2-cycle read).

---
 rtl/lsu_pkg.sv | 27 ++
 rtl/lsu_load_format.sv | 38 +++
 rtl/dmem_lsu_adapter.sv | 120 ++++++++++++
 tb/tb_dmem_lsu_adapter.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared encodings, lane mask helper and pipe metadata for the load/store adapter
package lsu_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    // Per-request information that travels alongside the RAM read through both stages
    typedef struct packed {
        logic [1:0] off;
        logic [1:0] size;
        logic       uns;
        logic       we;
        logic       err;
    } pipe_meta_t;

    // Byte lanes touched by an access of the given size at the given byte offset
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_B:    lane_mask = 4'b0001 << off;
            SZ_H:    lane_mask = 4'b0011 << off;
            SZ_W:    lane_mask = 4'b1111;
            default: lane_mask = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_format.sv
// rtl/lsu_load_format.sv - lane select and sign/zero extension of a 32-bit memory word
module lsu_load_format
    import lsu_pkg::*;
(
    input  logic [31:0] dout_i,
    input  logic [1:0]  off_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic        zero_i,
    output logic [31:0] rdata_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Pick the addressed lane, then extend it to 32 bits; stores and errors read as zero
    always_comb begin
        byte_v  = dout_i[7:0];
        half_v  = off_i[1] ? dout_i[31:16] : dout_i[15:0];
        rdata_o = '0;
        case (off_i)
            2'd0:    byte_v = dout_i[7:0];
            2'd1:    byte_v = dout_i[15:8];
            2'd2:    byte_v = dout_i[23:16];
            default: byte_v = dout_i[31:24];
        endcase
        case (size_i)
            SZ_B:    rdata_o = unsigned_i ? {24'd0, byte_v} : {{24{byte_v[7]}}, byte_v};
            SZ_H:    rdata_o = unsigned_i ? {16'd0, half_v} : {{16{half_v[15]}}, half_v};
            SZ_W:    rdata_o = dout_i;
            default: rdata_o = '0;
        endcase
        if (zero_i) begin
            rdata_o = '0;
        end
    end

endmodule

// File: rtl/dmem_lsu_adapter.sv
// rtl/dmem_lsu_adapter.sv - valid/ready load/store front end for a 2-cycle byte-write block RAM
module dmem_lsu_adapter
    import lsu_pkg::*;
#(
    parameter int RAM_DEPTH  = 4096,
    parameter int ADDR_WIDTH = 32,
    localparam int AW        = $clog2(RAM_DEPTH)
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  req_valid_in,
    output logic                  req_ready_out,
    input  logic [ADDR_WIDTH-1:0] req_addr_in,
    input  logic                  req_we_in,
    input  logic [1:0]            req_size_in,
    input  logic                  req_unsigned_in,
    input  logic [31:0]           req_wdata_in,
    output logic                  resp_valid_out,
    input  logic                  resp_ready_in,
    output logic [31:0]           resp_rdata_out,
    output logic                  resp_err_out,
    output logic [AW-1:0]         ram_addr_out,
    output logic [31:0]           ram_din_out,
    output logic [3:0]            ram_we_out,
    output logic                  ram_en_out,
    output logic                  ram_regce_out,
    output logic                  ram_rst_out,
    input  logic [31:0]           ram_dout_in
);

    localparam longint unsigned ADDR_LIMIT = 4 * longint'(RAM_DEPTH);

    logic       adv;
    logic       accept;
    logic       size_err;
    logic       req_err;
    logic       v1_q, v1_d;
    logic       v2_q, v2_d;
    pipe_meta_t m1_q, m1_d;
    pipe_meta_t m2_q, m2_d;
    pipe_meta_t meta_in;

    // The whole pipe, RAM registers included, moves only when the response slot can drain
    always_comb begin
        adv           = !(v2_q && !resp_ready_in);
        req_ready_out = adv && !rst_in;
        accept        = req_valid_in && req_ready_out;
        ram_en_out    = adv && !rst_in;
        ram_regce_out = adv;
        ram_rst_out   = rst_in;
    end

    // Classify the incoming request and build its store lanes and metadata
    always_comb begin
        case (req_size_in)
            SZ_B:    size_err = 1'b0;
            SZ_H:    size_err = req_addr_in[0];
            SZ_W:    size_err = (req_addr_in[1:0] != 2'b00);
            default: size_err = 1'b1;
        endcase
        req_err = size_err || (64'(req_addr_in) >= ADDR_LIMIT);

        case (req_size_in)
            SZ_B:    ram_din_out = {4{req_wdata_in[7:0]}};
            SZ_H:    ram_din_out = {2{req_wdata_in[15:0]}};
            default: ram_din_out = req_wdata_in;
        endcase
        ram_addr_out = req_addr_in[AW+1:2];
        ram_we_out   = (accept && req_we_in && !req_err) ?
                       lane_mask(req_size_in, req_addr_in[1:0]) : 4'b0000;

        meta_in.off  = req_addr_in[1:0];
        meta_in.size = req_size_in;
        meta_in.uns  = req_unsigned_in;
        meta_in.we   = req_we_in;
        meta_in.err  = req_err;
    end

    // Next state of the two valid/metadata stages: shift on adv, otherwise hold
    always_comb begin
        v1_d = v1_q;
        v2_d = v2_q;
        m1_d = m1_q;
        m2_d = m2_q;
        if (adv) begin
            v1_d = accept;
            m1_d = meta_in;
            v2_d = v1_q;
            m2_d = m1_q;
        end
    end

    // Stage registers; reset drops anything in flight
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            m1_q <= '0;
            m2_q <= '0;
        end else begin
            v1_q <= v1_d;
            v2_q <= v2_d;
            m1_q <= m1_d;
            m2_q <= m2_d;
        end
    end

    assign resp_valid_out = v2_q;
    assign resp_err_out   = m2_q.err;

    lsu_load_format u_load_format (
        .dout_i     (ram_dout_in),
        .off_i      (m2_q.off),
        .size_i     (m2_q.size),
        .unsigned_i (m2_q.uns),
        .zero_i     (m2_q.we || m2_q.err),
        .rdata_o    (resp_rdata_out)
    );

endmodule

// File: tb/tb_dmem_lsu_adapter.sv
// tb/tb_dmem_lsu_adapter.sv - randomized and directed bench for dmem_lsu_adapter with a byte-write RAM model
module tb_dmem_lsu_adapter;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        req_valid_in;
    logic        req_ready_out;
    logic [31:0] req_addr_in;
    logic        req_we_in;
    logic [1:0]  req_size_in;
    logic        req_unsigned_in;
    logic [31:0] req_wdata_in;
    logic        resp_valid_out;
    logic        resp_ready_in;
    logic [31:0] resp_rdata_out;
    logic        resp_err_out;
    logic [11:0] ram_addr_out;
    logic [31:0] ram_din_out;
    logic [3:0]  ram_we_out;
    logic        ram_en_out;
    logic        ram_regce_out;
    logic        ram_rst_out;
    logic [31:0] ram_dout_in;

    dmem_lsu_adapter #(.RAM_DEPTH(4096), .ADDR_WIDTH(32)) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .req_valid_in(req_valid_in), .req_ready_out(req_ready_out),
        .req_addr_in(req_addr_in), .req_we_in(req_we_in), .req_size_in(req_size_in),
        .req_unsigned_in(req_unsigned_in), .req_wdata_in(req_wdata_in),
        .resp_valid_out(resp_valid_out), .resp_ready_in(resp_ready_in),
        .resp_rdata_out(resp_rdata_out), .resp_err_out(resp_err_out),
        .ram_addr_out(ram_addr_out), .ram_din_out(ram_din_out), .ram_we_out(ram_we_out),
        .ram_en_out(ram_en_out), .ram_regce_out(ram_regce_out), .ram_rst_out(ram_rst_out),
        .ram_dout_in(ram_dout_in)
    );

    always #5 clk_in = ~clk_in;

    // Byte-write RAM, read-first, latch stage on ena, output register on regcea
    logic [31:0] ram_mem [0:4095];
    logic [31:0] ram_latch = '0;
    logic [31:0] ram_dout = '0;
    assign ram_dout_in = ram_dout;

    always @(posedge clk_in) begin
        if (ram_en_out) begin
            ram_latch <= ram_mem[ram_addr_out];
            for (int b = 0; b < 4; b++)
                if (ram_we_out[b]) ram_mem[ram_addr_out][8*b +: 8] <= ram_din_out[8*b +: 8];
        end
        if (ram_rst_out) ram_dout <= '0;
        else if (ram_regce_out) ram_dout <= ram_latch;
    end

    typedef struct { logic [31:0] rdata; logic err; int cyc; } resp_t;
    resp_t exp_q[$];
    resp_t obs_q[$];
    logic [7:0] smem [0:16383];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic acc_flag, we_seen;
    logic last_ready, last_rvalid, last_en, last_err;
    logic [3:0]  last_we;
    logic [31:0] last_rdata;

    // Reference: byte-addressed memory, each accepted request yields one expected response
    task automatic model_accept();
        logic [31:0] a, w, lane, rd;
        logic e;
        int base;
        a = req_addr_in;
        e = (req_size_in == 2'b11) || (req_size_in == 2'b01 && a[0]) ||
            (req_size_in == 2'b10 && a[1:0] != 2'b00) || (a >= 32'd16384);
        rd = '0;
        if (!e && req_we_in) begin
            for (int k = 0; k < (1 << req_size_in); k++) smem[int'(a) + k] = req_wdata_in[8*k +: 8];
        end else if (!e) begin
            base = int'(a) & ~3;
            w    = {smem[base+3], smem[base+2], smem[base+1], smem[base]};
            lane = w >> (8 * (int'(a) % 4));
            case (req_size_in)
                2'b00:   rd = req_unsigned_in ? {24'd0, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
                2'b01:   rd = req_unsigned_in ? {16'd0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
                default: rd = lane;
            endcase
        end
        exp_q.push_back('{rdata: rd, err: e, cyc: cyc});
    endtask

    task automatic step();
        @(negedge clk_in);
        last_ready  = req_ready_out;
        last_rvalid = resp_valid_out;
        last_rdata  = resp_rdata_out;
        last_err    = resp_err_out;
        last_en     = ram_en_out;
        last_we     = ram_we_out;
        if (ram_we_out != 4'b0000) we_seen = 1'b1;
        acc_flag = !rst_in && req_valid_in && req_ready_out;
        if (resp_valid_out && resp_ready_in)
            obs_q.push_back('{rdata: resp_rdata_out, err: resp_err_out, cyc: cyc});
        if (acc_flag) model_accept();
        @(posedge clk_in);
        cyc++;
        #1;
    endtask

    task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd);
        req_valid_in = 1'b1; req_we_in = we; req_size_in = sz;
        req_unsigned_in = uns; req_addr_in = addr; req_wdata_in = wd;
        for (int i = 0; i < 20; i++) begin
            step();
            if (acc_flag) break;
        end
        checks++;
        if (!acc_flag) begin
            failures++;
            $display("FAIL issue_timeout addr=%h not accepted within 20 cycles", addr);
        end
        req_valid_in = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && obs_q.size() < exp_q.size(); i++) step();
        step();
    endtask

    task automatic flush();
        drain();
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_reset();
        rst_in = 1'b1; resp_ready_in = 1'b1;
        req_valid_in = 1'b1; req_we_in = 1'b1; req_size_in = 2'b10;
        req_unsigned_in = 1'b0; req_addr_in = 32'h10; req_wdata_in = 32'hDEADBEEF;
        repeat (3) step();
        checks++; if (last_ready !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b exp=0", last_ready); end
        checks++; if (last_rvalid !== 1'b0) begin failures++; $display("FAIL rst_rvalid got=%b exp=0", last_rvalid); end
        checks++; if (last_en !== 1'b0) begin failures++; $display("FAIL rst_en got=%b exp=0", last_en); end
        checks++; if (last_we !== 4'b0000) begin failures++; $display("FAIL rst_we got=%b exp=0000", last_we); end
        rst_in = 1'b0; req_valid_in = 1'b0;
        step();
        checks++; if (last_ready !== 1'b1) begin failures++; $display("FAIL post_rst_ready got=%b exp=1", last_ready); end
        checks++; if (last_rvalid !== 1'b0) begin failures++; $display("FAIL post_rst_rvalid got=%b exp=0", last_rvalid); end
        checks++; if (ram_mem[4] !== 32'h0) begin failures++; $display("FAIL rst_store_written got=%h exp=0", ram_mem[4]); end
    endtask

    task automatic test_basic();
        flush();
        issue(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344);
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        drain();
        checks++;
        if (obs_q.size() != 2) begin
            failures++; $display("FAIL basic_count got=%0d exp=2", obs_q.size());
        end else begin
            checks++; if (obs_q[0].rdata !== 32'h0) begin failures++; $display("FAIL basic_store_rdata got=%h exp=0", obs_q[0].rdata); end
            checks++; if (obs_q[1].rdata !== 32'h11223344) begin failures++; $display("FAIL basic_lw got=%h exp=11223344", obs_q[1].rdata); end
            checks++; if (obs_q[1].err !== 1'b0) begin failures++; $display("FAIL basic_err got=%b exp=0", obs_q[1].err); end
            checks++; if (obs_q[1].cyc - exp_q[1].cyc != 2) begin failures++; $display("FAIL basic_latency got=%0d exp=2", obs_q[1].cyc - exp_q[1].cyc); end
        end
    endtask

    task automatic test_byte();
        logic [31:0] ex [4];
        ex = '{32'h0, 32'hFFFFFFAA, 32'h000000AA, 32'hAA223344};
        flush();
        issue(1'b1, 2'b00, 1'b0, 32'h13, 32'h123456AA);
        issue(1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
        issue(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        drain();
        checks++;
        if (obs_q.size() != 4) begin
            failures++; $display("FAIL byte_count got=%0d exp=4", obs_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (obs_q[i].rdata !== ex[i] || obs_q[i].err !== 1'b0) begin
                    failures++; $display("FAIL byte_resp%0d got=%h/%b exp=%h/0", i, obs_q[i].rdata, obs_q[i].err, ex[i]);
                end
            end
        end
    endtask

    task automatic test_errors();
        logic [31:0] ad [7];
        logic [1:0]  sz [7];
        logic        st [7];
        ad = '{32'h11, 32'h12, 32'h10, 32'h4000, 32'h11, 32'h4000, 32'h10};
        sz = '{2'b01, 2'b10, 2'b11, 2'b10, 2'b01, 2'b10, 2'b10};
        st = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        flush();
        we_seen = 1'b0;
        for (int i = 0; i < 6; i++) issue(st[i], sz[i], 1'b0, ad[i], 32'h5555BEEF);
        drain();
        checks++; if (we_seen !== 1'b0) begin failures++; $display("FAIL err_write got=%b exp=0", we_seen); end
        issue(st[6], sz[6], 1'b0, ad[6], 32'h0);
        drain();
        checks++;
        if (obs_q.size() != 7) begin
            failures++; $display("FAIL err_count got=%0d exp=7", obs_q.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (obs_q[i].err !== 1'b1 || obs_q[i].rdata !== 32'h0) begin
                    failures++; $display("FAIL err_resp%0d got=%h/%b exp=0/1", i, obs_q[i].rdata, obs_q[i].err);
                end
            end
            checks++;
            if (obs_q[6].err !== 1'b0 || obs_q[6].rdata !== 32'hAA223344) begin
                failures++; $display("FAIL err_after got=%h/%b exp=aa223344/0", obs_q[6].rdata, obs_q[6].err);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] held;
        for (int i = 0; i < 4; i++) issue(1'b1, 2'b10, 1'b0, 32'h20 + 4*i, 32'hA0000001 + i);
        flush();
        resp_ready_in = 1'b1;
        req_valid_in = 1'b1; req_we_in = 1'b0; req_size_in = 2'b10; req_unsigned_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_addr_in = 32'h20 + 4*i;
            step();
        end
        req_addr_in = 32'h2C;
        resp_ready_in = 1'b0;
        step();
        held = last_rdata;
        checks++; if (held !== 32'hA0000002) begin failures++; $display("FAIL stall_head got=%h exp=a0000002", held); end
        for (int i = 0; i < 3; i++) begin
            if (i > 0) step();
            checks++;
            if (last_ready !== 1'b0 || last_rvalid !== 1'b1 || last_rdata !== held) begin
                failures++; $display("FAIL stall_hold%0d ready=%b valid=%b rdata=%h exp 0/1/%h", i, last_ready, last_rvalid, last_rdata, held);
            end
        end
        resp_ready_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            if (acc_flag) break;
        end
        req_valid_in = 1'b0;
        drain();
        checks++;
        if (obs_q.size() != 4) begin
            failures++; $display("FAIL stall_count got=%0d exp=4", obs_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (obs_q[i].rdata !== 32'hA0000001 + i) begin
                    failures++; $display("FAIL stall_order%0d got=%h exp=%h", i, obs_q[i].rdata, 32'hA0000001 + i);
                end
            end
        end
    endtask

    task automatic test_raw();
        flush();
        issue(1'b1, 2'b10, 1'b0, 32'h40, 32'hCAFEBABE);
        issue(1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
        drain();
        checks++;
        if (obs_q.size() != 2 || obs_q[1].rdata !== 32'hCAFEBABE) begin
            failures++; $display("FAIL raw got=%h n=%0d exp=cafebabe n=2", (obs_q.size() > 1) ? obs_q[1].rdata : 32'h0, obs_q.size());
        end
    endtask

    task automatic test_reset_mid();
        flush();
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        issue(1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
        resp_ready_in = 1'b0; rst_in = 1'b1;
        step();
        rst_in = 1'b0; resp_ready_in = 1'b1;
        step();
        checks++; if (last_rvalid !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%b exp=0", last_rvalid); end
        repeat (5) step();
        checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL rstmid_stale got=%0d exp=0", obs_q.size()); end
        exp_q.delete();
        obs_q.delete();
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        issue(1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
        drain();
        checks++;
        if (obs_q.size() != 2 || obs_q[0].rdata !== 32'hAA223344 || obs_q[1].rdata !== 32'hCAFEBABE) begin
            failures++; $display("FAIL rstmid_persist n=%0d exp 2 words aa223344 cafebabe", obs_q.size());
        end
    endtask

    task automatic test_random();
        logic pending;
        flush();
        pending = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!pending && ($urandom % 4 != 0)) begin
                req_valid_in    = 1'b1;
                req_we_in       = $urandom % 2;
                req_size_in     = 2'($urandom % 4);
                req_unsigned_in = $urandom % 2;
                req_addr_in     = ($urandom % 16 == 0) ? 32'h4000 + $urandom_range(0, 7) : $urandom_range(0, 127);
                req_wdata_in    = $urandom;
                pending         = 1'b1;
            end
            resp_ready_in = ($urandom % 4) != 0;
            step();
            if (acc_flag) begin
                pending = 1'b0;
                req_valid_in = 1'b0;
            end
        end
        req_valid_in = 1'b0;
        resp_ready_in = 1'b1;
        drain();
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++; $display("FAIL rand_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i].rdata !== exp_q[i].rdata || obs_q[i].err !== exp_q[i].err) begin
                failures++; $display("FAIL rand_resp%0d got=%h/%b exp=%h/%b", i, obs_q[i].rdata, obs_q[i].err, exp_q[i].rdata, exp_q[i].err);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) ram_mem[i] = '0;
        for (int i = 0; i < 16384; i++) smem[i] = '0;
        rst_in = 1'b1; req_valid_in = 1'b0; req_addr_in = '0; req_we_in = 1'b0;
        req_size_in = 2'b00; req_unsigned_in = 1'b0; req_wdata_in = '0; resp_ready_in = 1'b1;
        acc_flag = 1'b0; we_seen = 1'b0;
        test_reset();
        test_basic();
        test_byte();
        test_errors();
        test_back_to_back();
        test_raw();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
